// File: rtl/sd_telemetry_logger_if.sv
// Block handoff between the telemetry logger and the SD SPI controller:
// request/ack/done handshake plus a byte read port into the handed-off buffer.
interface sd_telemetry_logger_if;
  logic        blk_wr_req_p;
  logic [31:0] blk_wr_addr_p;
  logic        blk_wr_ack_p;
  logic [8:0]  blk_rd_addr_p;
  logic [7:0]  blk_rd_data_p;
  logic        blk_wr_done_p;

  modport master (
    output blk_wr_req_p, blk_wr_addr_p, blk_rd_data_p,
    input  blk_wr_ack_p, blk_rd_addr_p, blk_wr_done_p
  );

  modport slave (
    input  blk_wr_req_p, blk_wr_addr_p, blk_rd_data_p,
    output blk_wr_ack_p, blk_rd_addr_p, blk_wr_done_p
  );
endinterface

// File: rtl/sd_telemetry_logger.sv
// Periodic telemetry sampler: packs {timestamp, channels} records into a
// double-buffered 512-byte block store and hands full blocks to the SD controller.
module sd_telemetry_logger #(
  parameter int          N_CH        = 4,
  parameter logic [31:0] START_BLOCK = 32'd0
) (
  input  logic                 clk210_p,
  input  logic                 reset_p,
  input  logic                 enable_p,
  input  logic                 flush_p,
  input  logic [31:0]          sample_period_p,
  input  logic [63:0]          timekeeper_time_p,
  input  logic [16*N_CH-1:0]   ch_data_p,
  input  logic                 sd_init_done_p,
  output logic [15:0]          overrun_cnt_p,
  output logic [15:0]          status_p,
  sd_telemetry_logger_if.master sd
);

  localparam int          R      = 8 + 2 * N_CH;
  localparam int          K      = 512 / R;
  localparam int          RW     = 8 * R;
  localparam logic [5:0]  R_LAST = 6'(R - 1);
  localparam logic [7:0]  K_LAST = 8'(K - 1);

  typedef enum logic [1:0] {P_IDLE, P_WRITE, P_PAD, P_SWAP} p_state_t;
  typedef enum logic [1:0] {H_IDLE, H_REQ, H_BUSY}          h_state_t;

  // ---------------- tick counter ----------------
  logic [31:0] tick_cnt_q, tick_cnt_d, period;
  logic        tick;

  always_comb begin
    period     = (sample_period_p < 32'd2) ? 32'd1 : sample_period_p;
    tick       = 1'b0;
    tick_cnt_d = '0;
    if (enable_p) begin
      if (tick_cnt_q >= period - 32'd1) tick = 1'b1;
      else                              tick_cnt_d = tick_cnt_q + 32'd1;
    end
  end

  // ---------------- packer ----------------
  p_state_t    p_state_q, p_state_d;
  logic [RW-1:0] snap_q, snap_d, snap_in;
  logic [9:0]  byte_idx_q, byte_idx_d;
  logic [5:0]  rec_byte_q, rec_byte_d;
  logic [7:0]  rec_cnt_q, rec_cnt_d;
  logic        flush_pend_q, flush_pend_d;
  logic        fill_idx_q, fill_idx_d;
  logic [1:0]  pend_q, pend_d;
  logic [15:0] ovr_q, ovr_d;
  logic        swap, drop, we, release_buf;
  logic [7:0]  wdata;

  // Record image with byte 0 in the MSBs so the packer just shifts left.
  always_comb begin
    snap_in = '0;
    snap_in[RW-1 -: 64] = timekeeper_time_p;
    for (int i = 0; i < N_CH; i++)
      snap_in[RW-65-16*i -: 16] = ch_data_p[16*i +: 16];
  end

  always_comb begin
    p_state_d    = p_state_q;
    snap_d       = snap_q;
    byte_idx_d   = byte_idx_q;
    rec_byte_d   = rec_byte_q;
    rec_cnt_d    = rec_cnt_q;
    flush_pend_d = flush_pend_q;
    fill_idx_d   = fill_idx_q;
    swap         = 1'b0;
    drop         = tick;
    we           = 1'b0;
    wdata        = 8'h00;
    case (p_state_q)
      P_IDLE: begin
        if (flush_p && rec_cnt_q != 8'd0) begin
          p_state_d = P_PAD;
        end else if (tick) begin
          drop       = 1'b0;
          snap_d     = snap_in;
          rec_byte_d = '0;
          p_state_d  = P_WRITE;
        end
      end
      P_WRITE: begin
        we         = 1'b1;
        wdata      = snap_q[RW-1 -: 8];
        snap_d     = snap_q << 8;
        byte_idx_d = byte_idx_q + 10'd1;
        rec_byte_d = rec_byte_q + 6'd1;
        if (flush_p) flush_pend_d = 1'b1;
        if (rec_byte_q == R_LAST) begin
          rec_cnt_d    = rec_cnt_q + 8'd1;
          flush_pend_d = 1'b0;
          if (rec_cnt_q == K_LAST || flush_pend_q || flush_p) p_state_d = P_PAD;
          else                                                p_state_d = P_IDLE;
        end
      end
      P_PAD: begin
        // index 512 means the records filled the block exactly
        if (byte_idx_q[9]) begin
          p_state_d = P_SWAP;
        end else begin
          we         = 1'b1;
          byte_idx_d = byte_idx_q + 10'd1;
          if (byte_idx_q == 10'd511) p_state_d = P_SWAP;
        end
      end
      P_SWAP: begin
        if (!pend_q[~fill_idx_q]) begin
          swap       = 1'b1;
          fill_idx_d = ~fill_idx_q;
          byte_idx_d = '0;
          rec_cnt_d  = '0;
          p_state_d  = P_IDLE;
        end
      end
      default: p_state_d = P_IDLE;
    endcase
    ovr_d = (drop && ovr_q != 16'hFFFF) ? ovr_q + 16'd1 : ovr_q;
  end

  // ---------------- handoff ----------------
  h_state_t    h_state_q, h_state_d;
  logic        hand_idx_q, hand_idx_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic [7:0]  mem [1024];

  always_comb begin
    h_state_d   = h_state_q;
    hand_idx_d  = hand_idx_q;
    addr_d      = addr_q;
    release_buf = 1'b0;
    case (h_state_q)
      H_IDLE: if (pend_q[hand_idx_q] && sd_init_done_p) h_state_d = H_REQ;
      H_REQ:  if (sd.blk_wr_ack_p) h_state_d = H_BUSY;
      H_BUSY: begin
        if (sd.blk_wr_done_p) begin
          release_buf = 1'b1;
          hand_idx_d  = ~hand_idx_q;
          addr_d      = addr_q + 32'd1;
          h_state_d   = H_IDLE;
        end
      end
      default: h_state_d = H_IDLE;
    endcase
    // release and close never target the same buffer: the fill buffer is never pending
    pend_d = pend_q;
    if (release_buf) pend_d[hand_idx_q] = 1'b0;
    if (swap)        pend_d[fill_idx_q] = 1'b1;
    rd_data_d = mem[{hand_idx_q, sd.blk_rd_addr_p}];
  end

  always_ff @(posedge clk210_p) begin
    if (we) mem[{fill_idx_q, byte_idx_q[8:0]}] <= wdata;
  end

  always_ff @(posedge clk210_p or posedge reset_p) begin
    if (reset_p) begin
      tick_cnt_q   <= '0;
      p_state_q    <= P_IDLE;
      snap_q       <= '0;
      byte_idx_q   <= '0;
      rec_byte_q   <= '0;
      rec_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
      fill_idx_q   <= 1'b0;
      pend_q       <= '0;
      ovr_q        <= '0;
      h_state_q    <= H_IDLE;
      hand_idx_q   <= 1'b0;
      addr_q       <= START_BLOCK;
      rd_data_q    <= '0;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      p_state_q    <= p_state_d;
      snap_q       <= snap_d;
      byte_idx_q   <= byte_idx_d;
      rec_byte_q   <= rec_byte_d;
      rec_cnt_q    <= rec_cnt_d;
      flush_pend_q <= flush_pend_d;
      fill_idx_q   <= fill_idx_d;
      pend_q       <= pend_d;
      ovr_q        <= ovr_d;
      h_state_q    <= h_state_d;
      hand_idx_q   <= hand_idx_d;
      addr_q       <= addr_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign sd.blk_wr_req_p  = (h_state_q == H_REQ);
  assign sd.blk_wr_addr_p = addr_q;
  assign sd.blk_rd_data_p = rd_data_q;
  assign overrun_cnt_p    = ovr_q;
  assign status_p = {rec_cnt_q, 3'b000, (p_state_q != P_IDLE), (h_state_q == H_BUSY),
                     (h_state_q == H_REQ), fill_idx_q, enable_p};

endmodule

// File: tb/tb_sd_telemetry_logger.sv
// Directed bench: three logger instances (N_CH=4, N_CH=3 with offset start
// block, and an overrun-saturation unit) exercised concurrently on one clock.
module tb_sd_telemetry_logger;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct { logic [8:0] addr; logic [7:0] exp; } rd_vec_t;

  // block A: 32 records, time 0123456789ABCD00+n, ch0=n, ch1=BEEF, ch2=1200+n, ch3=FACE
  rd_vec_t va [17] = '{
    '{9'd0, 8'h01}, '{9'd7, 8'h00}, '{9'd8, 8'h00}, '{9'd9, 8'h00}, '{9'd10, 8'hBE},
    '{9'd15, 8'hCE}, '{9'd87, 8'h05}, '{9'd89, 8'h05}, '{9'd92, 8'h12}, '{9'd93, 8'h05},
    '{9'd281, 8'h11}, '{9'd496, 8'h01}, '{9'd503, 8'h1F}, '{9'd505, 8'h1F},
    '{9'd508, 8'h12}, '{9'd509, 8'h1F}, '{9'd511, 8'hCE}};
  // block B: 3 identical records then zeros (flush)
  rd_vec_t vb [11] = '{
    '{9'd0, 8'hFE}, '{9'd7, 8'h10}, '{9'd8, 8'h5A}, '{9'd9, 8'h5A}, '{9'd10, 8'h22},
    '{9'd15, 8'h44}, '{9'd32, 8'hFE}, '{9'd47, 8'h44}, '{9'd48, 8'h00}, '{9'd100, 8'h00},
    '{9'd511, 8'h00}};
  // N_CH=3 block 0: time 112233445566_nnnn, ch0=n, ch1=C0DE, ch2=~n
  rd_vec_t vc [16] = '{
    '{9'd0, 8'h11}, '{9'd5, 8'h66}, '{9'd7, 8'h00}, '{9'd9, 8'h00}, '{9'd10, 8'hC0},
    '{9'd11, 8'hDE}, '{9'd12, 8'hFF}, '{9'd13, 8'hFF}, '{9'd149, 8'h0A}, '{9'd153, 8'hF5},
    '{9'd497, 8'h23}, '{9'd499, 8'h23}, '{9'd503, 8'hDC}, '{9'd504, 8'h00},
    '{9'd507, 8'h00}, '{9'd511, 8'h00}};
  // N_CH=3 block 1: samples 36..71
  rd_vec_t vd [8] = '{
    '{9'd0, 8'h11}, '{9'd7, 8'h24}, '{9'd9, 8'h24}, '{9'd13, 8'hDB},
    '{9'd499, 8'h47}, '{9'd503, 8'hB8}, '{9'd504, 8'h00}, '{9'd511, 8'h00}};

  // ---------------- instance N_CH=4 ----------------
  logic        rst4, en4, fl4, init4;
  logic [31:0] per4;
  logic [63:0] tk4, ch4;
  logic [15:0] ovr4, st4;
  sd_telemetry_logger_if if4();
  sd_telemetry_logger #(.N_CH(4), .START_BLOCK(32'd0)) u4 (
    .clk210_p(clk), .reset_p(rst4), .enable_p(en4), .flush_p(fl4),
    .sample_period_p(per4), .timekeeper_time_p(tk4), .ch_data_p(ch4),
    .sd_init_done_p(init4), .overrun_cnt_p(ovr4), .status_p(st4), .sd(if4));

  // ---------------- instance N_CH=3 ----------------
  logic        rst3, en3, fl3, init3;
  logic [31:0] per3;
  logic [63:0] tk3;
  logic [47:0] ch3;
  logic [15:0] ovr3, st3;
  sd_telemetry_logger_if if3();
  sd_telemetry_logger #(.N_CH(3), .START_BLOCK(32'h100)) u3 (
    .clk210_p(clk), .reset_p(rst3), .enable_p(en3), .flush_p(fl3),
    .sample_period_p(per3), .timekeeper_time_p(tk3), .ch_data_p(ch3),
    .sd_init_done_p(init3), .overrun_cnt_p(ovr3), .status_p(st3), .sd(if3));

  // ---------------- saturation instance ----------------
  logic        rsts, ens, fls, inits;
  logic [31:0] pers;
  logic [63:0] tks, chs;
  logic [15:0] ovrs, sts;
  sd_telemetry_logger_if ifs();
  sd_telemetry_logger #(.N_CH(4), .START_BLOCK(32'd0)) us (
    .clk210_p(clk), .reset_p(rsts), .enable_p(ens), .flush_p(fls),
    .sample_period_p(pers), .timekeeper_time_p(tks), .ch_data_p(chs),
    .sd_init_done_p(inits), .overrun_cnt_p(ovrs), .status_p(sts), .sd(ifs));

  task automatic test4();
    int seen;
    rst4 = 1; en4 = 0; fl4 = 0; per4 = 32'd100; tk4 = '0; ch4 = '0; init4 = 0;
    if4.blk_wr_ack_p = 0; if4.blk_rd_addr_p = '0; if4.blk_wr_done_p = 0;
    cyc(3);
    chk("u4_rst_req", if4.blk_wr_req_p, 0);
    chk("u4_rst_addr", if4.blk_wr_addr_p, 0);
    chk("u4_rst_rd", if4.blk_rd_data_p, 0);
    chk("u4_rst_ovr", ovr4, 0);
    chk("u4_rst_status", st4, 0);
    rst4 = 0; cyc(2);
    init4 = 1; en4 = 1;
    for (int n = 0; n < 32; n++) begin
      tk4 = 64'h0123_4567_89AB_CD00 + 64'(n);
      ch4 = {16'hFACE, 16'h1200 + 16'(n), 16'hBEEF, 16'(n)};
      cyc(100);
    end
    en4 = 0;
    for (int i = 0; i < 100 && !if4.blk_wr_req_p; i++) cyc(1);
    chk("u4_a_req", if4.blk_wr_req_p, 1);
    chk("u4_a_addr", if4.blk_wr_addr_p, 0);
    chk("u4_a_ovr", ovr4, 0);
    chk("u4_a_fillidx", st4[1], 1);
    chk("u4_a_reqbit", st4[2], 1);
    for (int i = 0; i < 17; i++) begin
      if4.blk_rd_addr_p = va[i].addr; cyc(1);
      chk($sformatf("u4_a_byte%0d", va[i].addr), if4.blk_rd_data_p, va[i].exp);
    end
    if4.blk_wr_ack_p = 1; cyc(1); if4.blk_wr_ack_p = 0;
    chk("u4_a_busy", st4[3], 1);
    chk("u4_a_req_after_ack", if4.blk_wr_req_p, 0);
    if4.blk_wr_done_p = 1; cyc(1); if4.blk_wr_done_p = 0;
    chk("u4_a_addr_inc", if4.blk_wr_addr_p, 1);
    chk("u4_a_idle", st4[3], 0);

    // period 5 with R=16: 12 ticks in 60 cycles, 3 accepted, 9 dropped
    per4 = 32'd5; tk4 = 64'hFEDC_BA98_7654_3210;
    ch4 = {16'h4444, 16'h3333, 16'h2222, 16'h5A5A};
    en4 = 1; cyc(60); en4 = 0; cyc(30);
    chk("u4_p5_ovr", ovr4, 9);
    chk("u4_p5_recs", st4[15:8], 3);

    fl4 = 1; cyc(1); fl4 = 0;
    for (int i = 0; i < 700 && !if4.blk_wr_req_p; i++) cyc(1);
    chk("u4_b_req", if4.blk_wr_req_p, 1);
    chk("u4_b_addr", if4.blk_wr_addr_p, 1);
    for (int i = 0; i < 11; i++) begin
      if4.blk_rd_addr_p = vb[i].addr; cyc(1);
      chk($sformatf("u4_b_byte%0d", vb[i].addr), if4.blk_rd_data_p, vb[i].exp);
    end
    if4.blk_wr_ack_p = 1; cyc(1); if4.blk_wr_ack_p = 0;
    if4.blk_wr_done_p = 1; cyc(1); if4.blk_wr_done_p = 0;
    chk("u4_b_addr_inc", if4.blk_wr_addr_p, 2);

    fl4 = 1; cyc(1); fl4 = 0;
    seen = 0;
    for (int i = 0; i < 600; i++) begin
      cyc(1);
      if (if4.blk_wr_req_p) seen++;
    end
    chk("u4_empty_flush_req", seen, 0);
    chk("u4_empty_flush_busy", st4[4], 0);
  endtask

  task automatic test3();
    rst3 = 1; en3 = 0; fl3 = 0; per3 = 32'd50; tk3 = '0; ch3 = '0; init3 = 0;
    if3.blk_wr_ack_p = 0; if3.blk_rd_addr_p = '0; if3.blk_wr_done_p = 0;
    cyc(3);
    chk("u3_rst_addr", if3.blk_wr_addr_p, 32'h100);
    rst3 = 0; cyc(2);
    en3 = 1;
    // 82 ticks: 72 fill both buffers, last 10 arrive while stuck in swap
    for (int n = 0; n < 82; n++) begin
      tk3 = {48'h1122_3344_5566, 16'(n)};
      ch3 = {~16'(n), 16'hC0DE, 16'(n)};
      cyc(50);
    end
    en3 = 0; cyc(5);
    chk("u3_noinit_req", if3.blk_wr_req_p, 0);
    chk("u3_full_ovr", ovr3, 10);
    chk("u3_full_busy", st3[4], 1);
    chk("u3_full_recs", st3[15:8], 36);

    init3 = 1;
    for (int i = 0; i < 10 && !if3.blk_wr_req_p; i++) cyc(1);
    chk("u3_c_req", if3.blk_wr_req_p, 1);
    chk("u3_c_addr", if3.blk_wr_addr_p, 32'h100);
    for (int i = 0; i < 16; i++) begin
      if3.blk_rd_addr_p = vc[i].addr; cyc(1);
      chk($sformatf("u3_c_byte%0d", vc[i].addr), if3.blk_rd_data_p, vc[i].exp);
    end
    if3.blk_wr_ack_p = 1; cyc(1); if3.blk_wr_ack_p = 0;
    if3.blk_wr_done_p = 1; cyc(1); if3.blk_wr_done_p = 0;
    for (int i = 0; i < 10 && !if3.blk_wr_req_p; i++) cyc(1);
    chk("u3_d_req", if3.blk_wr_req_p, 1);
    chk("u3_d_addr", if3.blk_wr_addr_p, 32'h101);
    cyc(2);
    chk("u3_resume_fillidx", st3[1], 0);
    chk("u3_resume_recs", st3[15:8], 0);
    for (int i = 0; i < 8; i++) begin
      if3.blk_rd_addr_p = vd[i].addr; cyc(1);
      chk($sformatf("u3_d_byte%0d", vd[i].addr), if3.blk_rd_data_p, vd[i].exp);
    end
    if3.blk_wr_ack_p = 1; cyc(1); if3.blk_wr_ack_p = 0;
    tk3 = {48'h1122_3344_5566, 16'd99}; ch3 = {~16'd99, 16'hC0DE, 16'd99};
    en3 = 1; cyc(80); en3 = 0; cyc(2);
    chk("u3_resume_one_rec", st3[15:8], 1);
    if3.blk_rd_addr_p = 9'd9; cyc(1);
    chk("u3_pre_rst_rd", if3.blk_rd_data_p, 8'h24);
    chk("u3_pre_rst_busy", st3[3], 1);
    #2 rst3 = 1;
    #1;
    chk("u3_mid_rst_req", if3.blk_wr_req_p, 0);
    chk("u3_mid_rst_addr", if3.blk_wr_addr_p, 32'h100);
    chk("u3_mid_rst_rd", if3.blk_rd_data_p, 0);
    chk("u3_mid_rst_ovr", ovr3, 0);
    chk("u3_mid_rst_status", st3, 0);
    cyc(2); rst3 = 0;
  endtask

  task automatic test_sat();
    rsts = 1; ens = 0; fls = 0; pers = 32'd1; tks = '0; chs = '0; inits = 0;
    ifs.blk_wr_ack_p = 0; ifs.blk_rd_addr_p = '0; ifs.blk_wr_done_p = 0;
    cyc(3); rsts = 0; cyc(1);
    ens = 1;
    cyc(67500);
    chk("us_ovr_sat", ovrs, 16'hFFFF);
    cyc(10);
    chk("us_ovr_hold", ovrs, 16'hFFFF);
    chk("us_noinit_req", ifs.blk_wr_req_p, 0);
    ens = 0;
  endtask

  initial begin
    fork
      test4();
      test3();
      test_sat();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", ncmp);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sd_telemetry_logger.md
# sd_telemetry_logger

- Parametrised telemetry-to-SD logging engine.
- Samples N_CH 16-bit telemetry channels plus the 64-bit timekeeper time at a programmable period.
- Packs the samples into fixed-format records inside a double-buffered 512-byte block store.
- Hands each full block to the SD card SPI controller through a request/ack/done handshake, with incrementing block addresses.
- Sits between the telemetry sources (current ADC, die temperature, timekeeper) and the SD SPI controller.

## Interface
Parameters:
- N_CH, 4, number of 16-bit channels, 1..16
- START_BLOCK, 32'd0, first SD block address after reset

Ports:
- clk210_p  in  1  system clock
- reset_p  in  1  reset, asynchronous, active-high
- enable_p  in  1  logging enable
- flush_p  in  1  single-cycle pulse: close the current buffer early
- sample_period_p  in  32  cycles between samples; values 0 and 1 both mean every cycle
- timekeeper_time_p  in  64  timestamp
- ch_data_p  in  16*N_CH  channel i is at [16i+15:16i]
- sd_init_done_p  in  1  SD controller initialized
- blk_wr_req_p  out  1  block ready for transfer
- blk_wr_addr_p  out  32  SD block address, valid while req is high
- blk_wr_ack_p  in  1  controller accepted the request
- blk_rd_addr_p  in  9  byte index the controller reads from the handed-off buffer
- blk_rd_data_p  out  8  byte at blk_rd_addr_p, one-cycle latency
- blk_wr_done_p  in  1  single-cycle pulse: transfer finished, buffer released
- overrun_cnt_p  out  16  dropped samples, saturating
- status_p  out  16  see Operation

## Operation
Record layout:
- R = 8 + 2*N_CH bytes per record.
- Timestamp comes first, big-endian, then ch0..ch(N_CH-1), each big-endian.
- K = floor(512/R) records per block. Bytes K*R..511 are written as 0x00.

Tick counter:
- Runs only while enable_p = 1; it is cleared whenever enable_p = 0.
- Issues a tick every max(sample_period_p, 1) cycles.

Packer FSM:
- P_IDLE: on a tick, load the snapshot register (timestamp and all channels in the same cycle), then go to P_WRITE.
- P_WRITE: write one byte per cycle into the fill buffer, R cycles total, then return to P_IDLE.
  - When the record count reaches K, go to P_PAD instead.
- flush_p in P_IDLE with at least 1 record buffered: go to P_PAD. flush_p on an empty buffer is ignored.
  - flush_p in P_WRITE is remembered and acted on when the record ends.
- P_PAD: write 0x00 from the current index to byte 511, one byte per cycle, then go to P_SWAP.
- P_SWAP: wait until the other buffer is free, then toggle the fill-buffer index, mark the closed buffer as pending, and return to P_IDLE.

Drop rules:
- A tick that arrives while not in P_IDLE, or while flush/pad/swap is in progress, is dropped.
- Each dropped tick increments overrun_cnt_p, saturating at 0xFFFF.

Handoff FSM:
- H_IDLE: if a buffer is pending and sd_init_done_p = 1, go to H_REQ.
- H_REQ: hold blk_wr_req_p = 1 and blk_wr_addr_p stable until blk_wr_ack_p, then go to H_BUSY.
- H_BUSY: on blk_wr_done_p, free the buffer, increment the address (wraps at 2^32), and return to H_IDLE.

Block RAM:
- 1024x8: buffer index is the address MSB.
- Port A is the packer's write port; port B is the controller's read port, reading the handed-off buffer.

status_p:
- [0] enable_p
- [1] fill-buffer index
- [2] req pending
- [3] H_BUSY
- [4] packer not in P_IDLE
- [7:5] 0
- [15:8] records in the fill buffer

## Timing
- Reset values:
  - blk_wr_req_p = 0, blk_wr_addr_p = START_BLOCK, blk_rd_data_p = 0, overrun_cnt_p = 0, status_p = 0.
  - Both buffers free, fill index = 0, both FSMs idle.
- Reset mid-transfer aborts everything: any partial record and any pending block are discarded.
- Tick in cycle T: snapshot loaded at edge T, byte 0 written at T+1, last byte at T+R.
- Once P_SWAP sees the other buffer free, the swap takes effect at the next edge. blk_wr_req_p rises 1 cycle after the swap if sd_init_done_p = 1.
- blk_rd_data_p is registered: the address presented in cycle T gives its data in cycle T+1.
- blk_wr_done_p and the swap in the same cycle: the release takes effect first, so a swap waiting on that buffer completes 1 cycle later.
- blk_wr_ack_p or blk_wr_done_p outside their own state: ignored.
- The minimum useful sample period is R+1. A shorter period drops ticks and counts them in overrun_cnt_p.

## Test plan
- N_CH=4 (R=16, K=32), period 100, enable on; drive 32 samples with ch0 = sample number:
  - blk_wr_req_p rises with addr 0.
  - Reading bytes 8..9 of record n returns n big-endian.
  - No padding (K*R = 512).
- N_CH=3 (R=14, K=36), 36 samples:
  - Bytes 504..511 read 0x00.
  - Second block uses addr START_BLOCK+1 after done/ack cycles.
- Period 5 with R=16:
  - Each accepted sample drops 3 ticks.
  - overrun_cnt_p counts exactly the dropped ticks, and saturates at 0xFFFF when forced.
- Both buffers full with the controller never acking:
  - Further ticks are dropped and counted.
  - After done, the fill resumes in the freed buffer.
- flush_p after 3 records:
  - The block is handed off with 3 records followed by zeros.
  - flush_p on an empty buffer produces no request.
- sd_init_done_p held low: req stays 0 while blocks are pending. reset_p pulsed mid-H_BUSY: all outputs return to their reset values on the same edge.
